mem_arbiter: RTL and testbench

- Owns the single byte-wide RAM port and shares it between three requesters.
- Requester priority, highest first: ROB store commit, load buffer reads, instruction fetch.
- Serializes each access into byte transfers, assembles or extends read data, and returns a one-cycle finish pulse to the granted requester.
- Sits between the core (rob, lbuffer, ifetch) and the top-level RAM/IO interface.

---
 rtl/mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Owns the byte-wide RAM/IO port and shares it between the ROB (stores),
//   the load buffer and instruction fetch, in that priority order. Each
//   request is turned into 1, 2 or 4 byte transfers. Read bytes are
//   assembled and extended, and the granted requester gets a one-cycle
//   finish pulse.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                chip ready; low freezes every register
//   flush_in              misprediction flush (aborts reads, blocks read grants)
//   io_buffer_full_in     UART buffer full; stalls IO-space writes
//   mem_din_in            RAM read byte
//   mem_dout_out/mem_a_out/mem_wr_out   RAM write byte, byte address, write enable
//   if_*                  fetch request/address, finish pulse, fetched word
//   lb_*                  load request/address/type, finish pulse, extended data
//   rob_*                 store request/address/data/type, ready, finish pulse

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [1:0]  IO_HI_BITS = 2'b11
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        io_buffer_full_in,
    input  logic [7:0]                  mem_din_in,
    output logic [7:0]                  mem_dout_out,
    output logic [ADDR_W-1:0]           mem_a_out,
    output logic                        mem_wr_out,
    input  logic                        if_en_in,
    input  logic [ADDR_W-1:0]           if_pc_in,
    output logic                        if_finish_out,
    output logic [31:0]                 if_inst_out,
    input  logic                        lb_en_in,
    input  logic [ADDR_W-1:0]           lb_addr_in,
    input  logic [`INST_TYPE_WIDTH-1:0] lb_type_in,
    output logic                        lb_finish_out,
    output logic [31:0]                 lb_data_out,
    input  logic                        rob_en_in,
    input  logic [ADDR_W-1:0]           rob_addr_in,
    input  logic [31:0]                 rob_wdata_in,
    input  logic [`INST_TYPE_WIDTH-1:0] rob_type_in,
    output logic                        rob_rdy_out,
    output logic                        rob_finish_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    function automatic logic [2:0] load_bytes(input logic [`INST_TYPE_WIDTH-1:0] t);
        case (t)
            `LB, `LBU: load_bytes = 3'd1;
            `LH, `LHU: load_bytes = 3'd2;
            default:   load_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] store_bytes(input logic [`INST_TYPE_WIDTH-1:0] t);
        case (t)
            `SB:     store_bytes = 3'd1;
            `SH:     store_bytes = 3'd2;
            default: store_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic io_hit(input logic [ADDR_W-1:0] a);
        io_hit = (a[17:16] == IO_HI_BITS);
    endfunction

    // Transaction context latched at the grant edge
    state_e              state_q,    state_d;
    logic [2:0]          cnt_q,      cnt_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic [2:0]          nbytes_q,   nbytes_d;
    logic                sext_q,     sext_d;
    logic                rd_lb_q,    rd_lb_d;    // 1: load owns the read, 0: fetch
    logic [31:0]         buf_q,      buf_d;      // read bytes assembled so far

    // Registered outputs
    logic [ADDR_W-1:0]   mem_a_q,    mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q,   mem_wr_d;
    logic                if_fin_q,   if_fin_d;
    logic [31:0]         if_inst_q,  if_inst_d;
    logic                lb_fin_q,   lb_fin_d;
    logic [31:0]         lb_data_q,  lb_data_d;
    logic                rob_fin_q,  rob_fin_d;

    logic [2:0]          cnt_nx;
    logic [31:0]         merged;
    logic [31:0]         extended;
    logic [7:0]          wbyte_nx;

    assign cnt_nx = cnt_q + 3'd1;

    // READ: counter value c means the byte addressed at edge c-2 is on
    // mem_din_in now (one cycle of RAM latency plus the output register).
    always_comb begin
        merged = buf_q;
        case (cnt_q)
            3'd2:    merged[7:0]   = mem_din_in;
            3'd3:    merged[15:8]  = mem_din_in;
            3'd4:    merged[23:16] = mem_din_in;
            3'd5:    merged[31:24] = mem_din_in;
            default: merged        = buf_q;
        endcase
    end

    always_comb begin
        case (nbytes_q)
            3'd1:    extended = sext_q ? {{24{merged[7]}},  merged[7:0]}
                                       : {24'h0, merged[7:0]};
            3'd2:    extended = sext_q ? {{16{merged[15]}}, merged[15:0]}
                                       : {16'h0, merged[15:0]};
            default: extended = merged;
        endcase
    end

    always_comb begin
        case (cnt_nx)
            3'd1:    wbyte_nx = wdata_q[15:8];
            3'd2:    wbyte_nx = wdata_q[23:16];
            3'd3:    wbyte_nx = wdata_q[31:24];
            default: wbyte_nx = wdata_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        nbytes_d   = nbytes_q;
        sext_d     = sext_q;
        rd_lb_d    = rd_lb_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_inst_d  = if_inst_q;
        lb_data_d  = lb_data_q;
        if_fin_d   = 1'b0;
        lb_fin_d   = 1'b0;
        rob_fin_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                mem_wr_d = 1'b0;
                // A store is committed and is never held back by flush.
                if (rob_en_in) begin
                    state_d    = S_WRITE;
                    cnt_d      = 3'd0;
                    addr_d     = rob_addr_in;
                    wdata_d    = rob_wdata_in;
                    nbytes_d   = store_bytes(rob_type_in);
                    mem_a_d    = rob_addr_in;
                    mem_dout_d = rob_wdata_in[7:0];
                    mem_wr_d   = !(io_hit(rob_addr_in) && io_buffer_full_in);
                end else if (!flush_in && lb_en_in) begin
                    state_d  = S_READ;
                    cnt_d    = 3'd1;
                    addr_d   = lb_addr_in;
                    nbytes_d = load_bytes(lb_type_in);
                    sext_d   = (lb_type_in == `LB) || (lb_type_in == `LH);
                    rd_lb_d  = 1'b1;
                    buf_d    = 32'h0;
                    mem_a_d  = lb_addr_in;
                end else if (!flush_in && if_en_in) begin
                    state_d  = S_READ;
                    cnt_d    = 3'd1;
                    addr_d   = if_pc_in;
                    nbytes_d = 3'd4;
                    sext_d   = 1'b0;
                    rd_lb_d  = 1'b0;
                    buf_d    = 32'h0;
                    mem_a_d  = if_pc_in;
                end
            end

            S_READ: begin
                mem_wr_d = 1'b0;
                if (flush_in) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q < nbytes_q)
                        mem_a_d = addr_q + ADDR_W'(cnt_q);
                    buf_d = merged;
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        if (rd_lb_q) begin
                            lb_fin_d  = 1'b1;
                            lb_data_d = extended;
                        end else begin
                            if_fin_d  = 1'b1;
                            if_inst_d = merged;
                        end
                    end else begin
                        cnt_d = cnt_nx;
                    end
                end
            end

            S_WRITE: begin
                // mem_wr_q high means byte cnt_q was written this cycle;
                // low means the IO stall held it, so present it again.
                if (mem_wr_q) begin
                    if (cnt_nx == nbytes_q) begin
                        state_d   = S_IDLE;
                        cnt_d     = 3'd0;
                        mem_wr_d  = 1'b0;
                        rob_fin_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_nx;
                        mem_a_d    = addr_q + ADDR_W'(cnt_nx);
                        mem_dout_d = wbyte_nx;
                        mem_wr_d   = !(io_hit(addr_q) && io_buffer_full_in);
                    end
                end else begin
                    mem_wr_d = !(io_hit(addr_q) && io_buffer_full_in);
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = 3'd0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            nbytes_q   <= 3'd0;
            sext_q     <= 1'b0;
            rd_lb_q    <= 1'b0;
            buf_q      <= 32'h0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h0;
            mem_wr_q   <= 1'b0;
            if_fin_q   <= 1'b0;
            if_inst_q  <= 32'h0;
            lb_fin_q   <= 1'b0;
            lb_data_q  <= 32'h0;
            rob_fin_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            nbytes_q   <= nbytes_d;
            sext_q     <= sext_d;
            rd_lb_q    <= rd_lb_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_fin_q   <= if_fin_d;
            if_inst_q  <= if_inst_d;
            lb_fin_q   <= lb_fin_d;
            lb_data_q  <= lb_data_d;
            rob_fin_q  <= rob_fin_d;
        end
    end

    assign mem_a_out      = mem_a_q;
    assign mem_dout_out   = mem_dout_q;
    assign mem_wr_out     = mem_wr_q;
    assign if_finish_out  = if_fin_q;
    assign if_inst_out    = if_inst_q;
    assign lb_finish_out  = lb_fin_q;
    assign lb_data_out    = lb_data_q;
    assign rob_finish_out = rob_fin_q;
    assign rob_rdy_out    = (state_q == S_IDLE) && !(if_fin_q || lb_fin_q || rob_fin_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read byte RAM model.
// Latencies below are counted in clock edges from the cycle a request is
// raised to the cycle its finish pulse is seen: grant edge + (N+1) for reads,
// grant edge + N for writes.

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_en, if_fin;
    logic [31:0] if_pc, if_inst;
    logic        lb_en, lb_fin;
    logic [31:0] lb_addr, lb_data;
    logic [`INST_TYPE_WIDTH-1:0] lb_type, rob_type;
    logic        rob_en, rob_rdy, rob_fin;
    logic [31:0] rob_addr, rob_wdata;

    int nchecks = 0;
    int nerr    = 0;
    int edges, wrs, e1, e2;

    // RAM model; shares the ready domain with the arbiter, so it freezes too
    logic [7:0]  ram [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr;
    logic [7:0]  pl_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    mem_arbiter #(.ADDR_W(32), .IO_HI_BITS(2'b11)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .io_buffer_full_in(io_full),
        .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a), .mem_wr_out(mem_wr),
        .if_en_in(if_en), .if_pc_in(if_pc), .if_finish_out(if_fin), .if_inst_out(if_inst),
        .lb_en_in(lb_en), .lb_addr_in(lb_addr), .lb_type_in(lb_type),
        .lb_finish_out(lb_fin), .lb_data_out(lb_data),
        .rob_en_in(rob_en), .rob_addr_in(rob_addr), .rob_wdata_in(rob_wdata),
        .rob_type_in(rob_type), .rob_rdy_out(rob_rdy), .rob_finish_out(rob_fin)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    // Step until the selected finish (0 fetch, 1 load, 2 store) is seen;
    // edges = -1 on timeout. wrs counts cycles with mem_wr_out high.
    task automatic wait_fin(input int which, input int max, output int n, output int w);
        logic f;
        n = 0; w = 0;
        for (int i = 0; i < max; i++) begin
            step();
            n++;
            if (mem_wr) w++;
            f = (which == 0) ? if_fin : (which == 1) ? lb_fin : rob_fin;
            if (f) return;
        end
        n = -1;
    endtask

    function automatic logic [31:0] ramw(input logic [17:0] a);
        ramw = {ram[a + 18'd3], ram[a + 18'd2], ram[a + 18'd1], ram[a]};
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        if_en = 1'b0; if_pc = 32'h0;
        lb_en = 1'b0; lb_addr = 32'h0; lb_type = `LW;
        rob_en = 1'b0; rob_addr = 32'h0; rob_wdata = 32'h0; rob_type = `SW;

        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h10); poke(18'h103, 8'h00);
        poke(18'h104, 8'h78); poke(18'h105, 8'h56); poke(18'h106, 8'h34); poke(18'h107, 8'h12);
        poke(18'h200, 8'h80);
        poke(18'h210, 8'h34); poke(18'h211, 8'h92);
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_wr_a_dout", {mem_wr, mem_a[22:0], mem_dout}, 32'h0);
        chk("rst_finishes",  {29'h0, if_fin, lb_fin, rob_fin}, 32'h0);
        chk("rst_if_inst",   if_inst, 32'h0);
        chk("rst_lb_data",   lb_data, 32'h0);
        chk("rst_rob_rdy",   {31'h0, rob_rdy}, 32'h1);

        // Word fetch
        if_pc = 32'h100; if_en = 1'b1;
        wait_fin(0, 20, edges, wrs);
        chk("fetch_edges", edges, 6);
        chk("fetch_no_wr", wrs, 0);
        chk("fetch_inst",  if_inst, 32'h00100513);
        if_en = 1'b0;
        step();
        chk("fetch_pulse_1cyc", {31'h0, if_fin}, 32'h0);

        // Byte/half loads with extension
        lb_addr = 32'h200; lb_type = `LB; lb_en = 1'b1;
        wait_fin(1, 20, edges, wrs);
        chk("lb_edges", edges, 3);
        chk("lb_data",  lb_data, 32'hFFFFFF80);
        lb_en = 1'b0; step();

        lb_type = `LBU; lb_en = 1'b1;
        wait_fin(1, 20, edges, wrs);
        chk("lbu_data", lb_data, 32'h00000080);
        lb_en = 1'b0; step();

        lb_addr = 32'h210; lb_type = `LH; lb_en = 1'b1;
        wait_fin(1, 20, edges, wrs);
        chk("lh_edges", edges, 4);
        chk("lh_data",  lb_data, 32'hFFFF9234);
        lb_en = 1'b0; step();

        lb_type = `LHU; lb_en = 1'b1;
        wait_fin(1, 20, edges, wrs);
        chk("lhu_data", lb_data, 32'h00009234);
        lb_en = 1'b0; step();

        // All three at once: store, then load, then fetch
        if_pc = 32'h104; if_en = 1'b1;
        lb_addr = 32'h200; lb_type = `LBU; lb_en = 1'b1;
        rob_addr = 32'h300; rob_wdata = 32'hDEADBEEF; rob_type = `SW; rob_en = 1'b1;
        wait_fin(2, 20, edges, wrs);
        chk("prio_sw_edges", edges, 5);
        chk("prio_sw_wrs",   wrs, 4);
        chk("prio_rdy_on_fin", {31'h0, rob_rdy}, 32'h0);
        rob_en = 1'b0;
        wait_fin(1, 20, edges, wrs);
        chk("prio_lb_edges", edges, 3);
        chk("prio_lb_data",  lb_data, 32'h00000080);
        lb_en = 1'b0;
        wait_fin(0, 20, edges, wrs);
        chk("prio_if_edges", edges, 6);
        chk("prio_if_inst",  if_inst, 32'h12345678);
        if_en = 1'b0; step();
        chk("prio_ram_word", ramw(18'h300), 32'hDEADBEEF);

        // IO-space byte store stalled by a full UART buffer for 3 cycles
        rob_addr = 32'h30000; rob_wdata = 32'h1234565A; rob_type = `SB;
        io_full = 1'b1; rob_en = 1'b1;
        step();
        chk("io_stall0_wr", {31'h0, mem_wr}, 32'h0);
        chk("io_stall0_a",  mem_a, 32'h30000);
        chk("io_busy_rdy",  {31'h0, rob_rdy}, 32'h0);
        step();
        chk("io_stall1_wr", {31'h0, mem_wr}, 32'h0);
        step();
        chk("io_stall2_wr", {31'h0, mem_wr}, 32'h0);
        io_full = 1'b0;
        step();
        chk("io_write_wr_dout", {23'h0, mem_wr, mem_dout}, {23'h0, 1'b1, 8'h5A});
        chk("io_write_no_fin",  {31'h0, rob_fin}, 32'h0);
        step();
        chk("io_fin_wr", {30'h0, rob_fin, mem_wr}, 32'h2);
        rob_en = 1'b0;
        step();
        chk("io_fin_once", {31'h0, rob_fin}, 32'h0);
        chk("io_ram_byte", {24'h0, ram[18'h30000]}, 32'h5A);

        // Flush two cycles into a fetch aborts it; the retry completes
        if_pc = 32'h100; if_en = 1'b1;
        step(); step(); step();
        flush = 1'b1;
        step();
        chk("flush_no_fin",  {31'h0, if_fin}, 32'h0);
        chk("flush_idle",    {31'h0, rob_rdy}, 32'h1);
        chk("flush_inst_hold", if_inst, 32'h12345678);
        flush = 1'b0;
        wait_fin(0, 20, edges, wrs);
        chk("flush_retry_edges", edges, 6);
        chk("flush_retry_inst",  if_inst, 32'h00100513);
        if_en = 1'b0; step();

        // Flush held through a store: store completes, load held back
        rob_addr = 32'h310; rob_wdata = 32'hCAFEF00D; rob_type = `SW; rob_en = 1'b1;
        lb_addr = 32'h200; lb_type = `LB; lb_en = 1'b1;
        flush = 1'b1;
        wait_fin(2, 20, edges, wrs);
        chk("flush_sw_edges", edges, 5);
        rob_en = 1'b0;
        step();
        chk("flush_blocks_lb", {31'h0, rob_rdy}, 32'h1);
        flush = 1'b0;
        wait_fin(1, 20, edges, wrs);
        chk("after_flush_lb_edges", edges, 3);
        chk("after_flush_lb_data",  lb_data, 32'hFFFFFF80);
        lb_en = 1'b0; step();
        chk("flush_sw_ram", ramw(18'h310), 32'hCAFEF00D);

        // rdy low for 2 cycles mid-load
        lb_addr = 32'h300; lb_type = `LW; lb_en = 1'b1;
        step(); step();
        rdy = 1'b0;
        step(); step();
        rdy = 1'b1;
        wait_fin(1, 20, e1, wrs);
        e2 = (e1 < 0) ? -1 : e1 + 4;
        chk("rdy_edges", e2, 8);
        chk("rdy_data",  lb_data, 32'hDEADBEEF);
        lb_en = 1'b0; step();

        // Reset in the middle of a fetch
        if_pc = 32'h104; if_en = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst_state", {29'h0, mem_wr, if_fin, rob_rdy}, 32'h1);
        chk("midrst_inst",  if_inst, 32'h0);
        rst = 1'b0; if_en = 1'b0;
        step();
        chk("midrst_no_fin", {31'h0, if_fin}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
